lut_multiplier_pipe: RTL and testbench
======================================

Name: lut_multiplier_pipe

Overview:
- Pipelined, multi-lane successor to the single-constant LUT multiplier used in the compression datapath (DCT scaling and quantisation).
- Each accepted beat multiplies LANES signed fixed-point samples by coefficients read from a run-time-loadable coefficient table.
- Each product is rounded or truncated, shifted by FRAC, saturated to OUT_W, and emitted with a per-lane saturation flag.
- Sits between the DCT output stage and the quantiser packer; valid/ready on both sides.

Parameters:
- IN_W, 32, signed sample width.
- CONST_W, 18, signed coefficient width; coefficient value = coef / 2^FRAC.
- FRAC, 15, fractional bits of the coefficient; 1 <= FRAC < IN_W+CONST_W.
- OUT_W, 32, signed result width; OUT_W <= IN_W+CONST_W.
- LANES, 8, samples per beat.
- DEPTH, 64, coefficient table entries; power of two, >= LANES.
- AW, $clog2(DEPTH), table address width (derived; do not override).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- coef_we, input, 1, coefficient table write enable.
- coef_waddr, input, AW, coefficient write address.
- coef_wdata, input, CONST_W, signed coefficient to write.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept a beat.
- in_data, input, LANES*IN_W, lane i in bits [i*IN_W +: IN_W].
- in_idx, input, AW, table base index for lane 0.
- in_round, input, 1, 1 = round-half-up, 0 = truncate (floor).
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, LANES*OUT_W, lane i in bits [i*OUT_W +: OUT_W].
- out_sat, output, LANES, per-lane saturation flag.

Behaviour:
- Reset (asynchronous, active-high) clears all stage valid bits, out_valid, out_data and out_sat to 0.
  - The coefficient table is not reset; entries read before being written are undefined.
  - Reset mid-beat discards all in-flight beats. No output appears for them after reset is released.
- Handshake:
  - A beat transfers when valid && ready.
  - in_valid, in_data, in_idx and in_round are held stable while in_valid && !in_ready; out_data and out_sat are held stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Pipeline has three register stages (S1 coefficient read, S2 multiply, S3 round/shift/saturate). Latency is 3 cycles from input transfer to out_valid.
- Stall rule:
  - Global advance enable en = !s3_valid || out_ready.
  - in_ready = en, combinational from out_ready and s3_valid only, never from in_valid.
  - All stages hold when en = 0.
  - Throughput is one beat per cycle while out_ready = 1.
- Lane i coefficient = table[(in_idx + i) mod DEPTH]; the index wraps around the table end.
- Write/read collision: a beat accepted in the same cycle as a coef_we to an address it reads uses the OLD value. Writes are visible to beats accepted from the next cycle on.
- Coefficient writes are accepted every cycle regardless of stall state.
- Arithmetic per lane:
  - p = signed(a) * signed(coef), full width IN_W+CONST_W.
  - If in_round = 1, add 2^(FRAC-1).
  - Arithmetic shift right by FRAC.
  - If the result is > 2^(OUT_W-1)-1, clamp to max and set sat; if < -2^(OUT_W-1), clamp to min and set sat; otherwise sat = 0.
  - The rounding add uses IN_W+CONST_W+1 bits so it never overflows.
- in_round travels with its beat; mixed modes in consecutive beats are legal.

Decomposition:
- Package lut_mult_pkg holds:
  - the round_mode_e enum (RND_TRUNC, RND_HALF_UP);
  - a parameterised saturate function;
  - localparams for lane slicing helpers.
- One sub-module, lut_mult_lane: signed multiply, round, shift and saturate for one lane, with S2/S3 registers gated by en.
- The top holds the table, S1, valid bits and the handshake, and instantiates LANES lanes with a generate loop.

Test Plan:
- Basic scaling: all entries = 0x04000 (0.5), in_data lanes = 100, round = 1 -> all out_data = 50, out_sat = 0, out_valid exactly 3 cycles after transfer.
- Rounding: coef 0.5, a = 3 -> round 2 / trunc 1; a = -3 -> round -1 / trunc -2; alternate modes on back-to-back beats -> each result matches its own mode.
- Saturation: coef 0x10000 (2.0), a = 0x7FFFFFFF -> 0x7FFFFFFF with sat = 1; a = 0x80000000 -> 0x80000000 with sat = 1; a = 5 in another lane -> 10 with sat = 0.
- Wrap and collision:
  - table[k] = k; in_idx = 60, DEPTH = 64 -> lanes use coefs 60,61,62,63,0,1,2,3.
  - Write table[60] = 99 in the same cycle as that beat's transfer -> lane 0 uses 60; the next beat uses 99.
- Backpressure: stream 20 beats with random out_ready -> all 20 results arrive in order, none lost or duplicated, and output is stable while stalled.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid = 0 immediately; after release no stale beats appear and a new beat returns correctly after 3 cycles.

Source files
------------

// File: rtl/lut_mult_pkg.sv
// Shared types and helpers for the LUT multiplier pipeline.
//   round_mode_e : per-beat rounding mode carried down the pipe
//   sat_flags_t  : over/under-range flags produced by saturate()
//   saturate()   : range check of a wide signed value against an out_w-bit
//                  signed result; the caller clamps using the flags
package lut_mult_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  // Default geometry shared by the top and its lanes
  localparam int DEF_IN_W    = 32;
  localparam int DEF_CONST_W = 18;
  localparam int DEF_FRAC    = 15;
  localparam int DEF_OUT_W   = 32;
  localparam int DEF_LANES   = 8;
  localparam int DEF_DEPTH   = 64;

  // Working width of the range check; any lane intermediate is sign-extended
  // into this before comparing, so one function serves every OUT_W.
  localparam int SAT_W = 128;

  typedef struct packed {
    logic hi;  // value above the largest out_w-bit signed number
    logic lo;  // value below the smallest out_w-bit signed number
  } sat_flags_t;

  function automatic sat_flags_t saturate(input logic signed [SAT_W-1:0] x,
                                          input int unsigned             out_w);
    logic signed [SAT_W-1:0] maxv;
    logic signed [SAT_W-1:0] minv;
    maxv = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
    minv = ~maxv;  // -max-1 in two's complement
    saturate.hi = (x > maxv);
    saturate.lo = (x < minv);
  endfunction

endpackage

// File: rtl/lut_mult_lane.sv
// One lane of the LUT multiplier: S2 registers the full-width signed product,
// S3 registers the rounded, shifted and saturated result.
//   clk, rst : clock, async active-high reset
//   en       : pipeline advance enable; both stages hold when low
//   a, coef  : signed sample and coefficient from S1
//   rnd      : rounding mode of the beat in S1
//   y, sat   : S3 result and saturation flag
module lut_mult_lane
  import lut_mult_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int CONST_W = DEF_CONST_W,
  parameter int FRAC    = DEF_FRAC,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [IN_W-1:0]    a,
  input  logic signed [CONST_W-1:0] coef,
  input  round_mode_e               rnd,
  output logic        [OUT_W-1:0]   y,
  output logic                      sat
);

  localparam int PW = IN_W + CONST_W;
  localparam logic [PW:0]      HALF = (PW+1)'(1) << (FRAC - 1);
  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    prod_r;
  round_mode_e             rnd_r;
  logic        [PW:0]      sum;
  logic signed [PW:0]      shr;
  logic signed [SAT_W-1:0] shr_ext;
  sat_flags_t              flg;

  assign prod = PW'(a) * PW'(coef);

  // One extra bit keeps the half-up add from overflowing at the product max.
  assign sum     = {prod_r[PW-1], prod_r} + ((rnd_r == RND_HALF_UP) ? HALF : '0);
  assign shr     = $signed(sum) >>> FRAC;
  assign shr_ext = SAT_W'(shr);
  assign flg     = saturate(shr_ext, OUT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= '0;
      rnd_r  <= RND_TRUNC;
      y      <= '0;
      sat    <= 1'b0;
    end else if (en) begin
      prod_r <= prod;
      rnd_r  <= rnd;
      y      <= flg.hi ? MAXV : (flg.lo ? MINV : shr[OUT_W-1:0]);
      sat    <= flg.hi | flg.lo;
    end
  end

endmodule

// File: rtl/lut_multiplier_pipe.sv
// Multi-lane pipelined LUT multiplier between the DCT output stage and the
// quantiser packer. Each beat multiplies LANES signed samples by consecutive
// entries of a run-time-loadable coefficient table starting at in_idx.
//   coef_we/coef_waddr/coef_wdata : table write port, accepted every cycle
//   in_valid/in_ready/in_data/in_idx/in_round : input beat handshake
//   out_valid/out_ready/out_data/out_sat      : result beat handshake
// Stages: S1 coefficient read, S2 multiply, S3 round/shift/saturate.
module lut_multiplier_pipe
  import lut_mult_pkg::*;
#(
  parameter  int IN_W    = DEF_IN_W,
  parameter  int CONST_W = DEF_CONST_W,
  parameter  int FRAC    = DEF_FRAC,
  parameter  int OUT_W   = DEF_OUT_W,
  parameter  int LANES   = DEF_LANES,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_we,
  input  logic [AW-1:0]             coef_waddr,
  input  logic signed [CONST_W-1:0] coef_wdata,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IN_W-1:0]     in_data,
  input  logic [AW-1:0]             in_idx,
  input  logic                      in_round,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic [LANES-1:0]          out_sat
);

  localparam int STAGES = 3;

  logic signed [CONST_W-1:0]         tbl [DEPTH];
  logic [STAGES:1]                   vld_pipe;
  logic                              en;
  logic [LANES-1:0][IN_W-1:0]        s1_a;
  logic [LANES-1:0][CONST_W-1:0]     s1_coef;
  round_mode_e                       s1_rnd;
  logic [LANES-1:0][OUT_W-1:0]       lane_y;
  logic [LANES-1:0]                  lane_sat;

  // The whole pipe moves as one; only a blocked S3 can stall it.
  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = lane_y;
  assign out_sat   = lane_sat;

  // Table write is independent of stalls. A beat captured on the same edge
  // reads the pre-write contents because S1 samples tbl before the update.
  always_ff @(posedge clk) begin
    if (coef_we) tbl[coef_waddr] <= coef_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a    <= '0;
      s1_coef <= '0;
      s1_rnd  <= RND_TRUNC;
    end else if (en) begin
      s1_a   <= in_data;
      s1_rnd <= in_round ? RND_HALF_UP : RND_TRUNC;
      // AW-bit address arithmetic wraps around the end of the table.
      for (int i = 0; i < LANES; i++)
        s1_coef[i] <= tbl[AW'(in_idx + AW'(i))];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lut_mult_lane #(
      .IN_W   (IN_W),
      .CONST_W(CONST_W),
      .FRAC   (FRAC),
      .OUT_W  (OUT_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (s1_a[g]),
      .coef(s1_coef[g]),
      .rnd (s1_rnd),
      .y   (lane_y[g]),
      .sat (lane_sat[g])
    );
  end

endmodule

// File: tb/tb_lut_multiplier_pipe.sv
module tb_lut_multiplier_pipe;

  logic              clk;
  logic              rst;
  logic              coef_we;
  logic [5:0]        coef_waddr;
  logic [17:0]       coef_wdata;
  logic              in_valid;
  logic              in_ready;
  logic [255:0]      in_data;
  logic [5:0]        in_idx;
  logic              in_round;
  logic              out_valid;
  logic              out_ready;
  logic [255:0]      out_data;
  logic [7:0]        out_sat;

  logic [7:0][31:0]  in_vec;
  logic [7:0][31:0]  out_vec;
  assign in_data = in_vec;
  assign out_vec = out_data;

  int n_cmp = 0;
  int n_err = 0;

  lut_multiplier_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .coef_we   (coef_we),
    .coef_waddr(coef_waddr),
    .coef_wdata(coef_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_idx    (in_idx),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_table(input logic [17:0] v, input bit ramp);
    for (int k = 0; k < 64; k++) begin
      coef_we    = 1'b1;
      coef_waddr = 6'(k);
      coef_wdata = ramp ? 18'(k) : v;
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_sat !== 8'h00) begin n_err++; $display("FAIL reset_out_sat: got %h want 00", out_sat); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0][31:0] ev;
    logic [7:0][31:0] held;
    fill_table(18'h04000, 1'b0);
    for (int l = 0; l < 8; l++) begin in_vec[l] = 32'd100; ev[l] = 32'd50; end
    in_idx = 6'd0; in_round = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat1: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat2: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_lat3: got %b want 1", out_valid); end
    n_cmp++; if (out_vec !== ev) begin n_err++; $display("FAIL basic_data: got %h want %h", out_vec, ev); end
    n_cmp++; if (out_sat !== 8'h00) begin n_err++; $display("FAIL basic_sat: got %h want 00", out_sat); end
    held = out_vec;
    out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_stall_in_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if ({out_valid, out_vec} !== {1'b1, held}) begin n_err++; $display("FAIL basic_stall_hold: got %b/%h want 1/%h", out_valid, out_vec, held); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_rounding();
    int dv[4] = '{3, 3, -3, -3};
    bit rm[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int ex[4] = '{2, 1, -1, -2};
    logic [7:0][31:0] ev;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        for (int l = 0; l < 8; l++) in_vec[l] = 32'(dv[k]);
        in_round = rm[k];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 2) begin
        for (int l = 0; l < 8; l++) ev[l] = 32'(ex[k-2]);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL round_valid_%0d: got %b want 1", k-2, out_valid); end
        n_cmp++; if (out_vec !== ev) begin n_err++; $display("FAIL round_data_%0d: got %h want %h", k-2, out_vec, ev); end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    fill_table(18'h10000, 1'b0);
    in_vec = '0;
    in_vec[0] = 32'h7FFF_FFFF;
    in_vec[1] = 32'h8000_0000;
    in_vec[2] = 32'd5;
    in_round = 1'b0; in_idx = 6'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_vec[0] !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sat_max: got %h want 7fffffff", out_vec[0]); end
    n_cmp++; if (out_vec[1] !== 32'h8000_0000) begin n_err++; $display("FAIL sat_min: got %h want 80000000", out_vec[1]); end
    n_cmp++; if (out_vec[2] !== 32'd10) begin n_err++; $display("FAIL sat_lane2: got %h want 0000000a", out_vec[2]); end
    n_cmp++; if (out_sat !== 8'h03) begin n_err++; $display("FAIL sat_flags: got %h want 03", out_sat); end
    tick();
  endtask

  task automatic test_wrap_collision();
    int w1[8] = '{60, 61, 62, 63, 0, 1, 2, 3};
    logic [7:0][31:0] ev;
    fill_table(18'h0, 1'b1);
    for (int l = 0; l < 8; l++) in_vec[l] = 32'h0000_8000;
    in_idx = 6'd60; in_round = 1'b0; in_valid = 1'b1;
    coef_we = 1'b1; coef_waddr = 6'd60; coef_wdata = 18'd99;
    tick();
    coef_we = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    for (int l = 0; l < 8; l++) ev[l] = 32'(w1[l]);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_vec !== ev) begin n_err++; $display("FAIL wrap_old_coef: got %h want %h", out_vec, ev); end
    tick();
    ev[0] = 32'd99;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid2: got %b want 1", out_valid); end
    n_cmp++; if (out_vec !== ev) begin n_err++; $display("FAIL wrap_new_coef: got %h want %h", out_vec, ev); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [255:0] exp_q[$];
    logic [7:0][31:0] ev;
    logic [255:0] held;
    logic [255:0] want;
    int sent = 0;
    int recv = 0;
    bit stall_prev = 1'b0;
    bit in_fire;
    in_valid = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 20) begin
        for (int l = 0; l < 8; l++) in_vec[l] = 32'(sent + 1) << 15;
        in_idx = 6'(sent);
        in_round = sent[0];
        in_valid = 1'b1;
      end
      #1;
      if (stall_prev) begin
        n_cmp++; if ({out_valid, out_data} !== {1'b1, held}) begin n_err++; $display("FAIL bp_hold: got %b/%h want 1/%h", out_valid, out_data, held); end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL bp_extra_beat: got %h want none", out_data);
        end else begin
          want = exp_q.pop_front();
          n_cmp++; if (out_data !== want) begin n_err++; $display("FAIL bp_beat_%0d: got %h want %h", recv, out_data, want); end
        end
        recv++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      in_fire = in_valid && in_ready;
      tick();
      if (in_fire) begin
        for (int l = 0; l < 8; l++) ev[l] = 32'((sent + 1) * (sent + l));
        exp_q.push_back(ev);
        sent++;
        in_valid = 1'b0;
      end
    end
    n_cmp++; if (recv !== 20) begin n_err++; $display("FAIL bp_count: got %0d want 20", recv); end
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0][31:0] ev;
    out_ready = 1'b1;
    for (int l = 0; l < 8; l++) in_vec[l] = 32'h0000_8000;
    in_idx = 6'd0; in_round = 1'b0; in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstm_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstm_async_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rstm_async_data: got %h want 0", out_data); end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstm_stale_%0d: got %b want 0", k, out_valid); end
    end
    for (int l = 0; l < 8; l++) begin in_vec[l] = 32'h0001_0000; ev[l] = 32'(2 * (8 + l)); end
    in_idx = 6'd8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstm_new_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_vec !== ev) begin n_err++; $display("FAIL rstm_new_data: got %h want %h", out_vec, ev); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    coef_we = 1'b0; coef_waddr = '0; coef_wdata = '0;
    in_valid = 1'b0; in_vec = '0; in_idx = '0; in_round = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_wrap_collision();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
